instruction_fetch: RTL and testbench

//  Consumer side of the program counter interface. Reads the PC's i_addr and fetches
//  the instruction from instruction memory over a req/ack handshake.

---
 rtl/instruction_fetch.sv | 106 ++++++++++
 tb/tb_instruction_fetch.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetches instructions over a req/ack memory port and hands them to decode via valid/ready
module instruction_fetch #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              pc_increment,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_addr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              fetch_err
);
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
    typedef enum logic [1:0] {IDLE, REQ, HOLD, ERR} state_t;
    state_t            state, state_d;
    logic              mem_req_d, instr_valid_d, fetch_err_d, discard, discard_d, timeout_hit;
    logic [ADDR_W-1:0] mem_addr_d, instr_addr_d;
    logic [DATA_W-1:0] instr_d;
    logic [CW-1:0]     cnt, cnt_d;
    assign timeout_hit  = (TIMEOUT != 0) && (int'(cnt) >= TIMEOUT - 1);
    assign pc_increment = (state == REQ) && mem_req && mem_ack && !flush && !discard;
    always_comb begin
        state_d       = state;
        mem_req_d     = mem_req;
        mem_addr_d    = mem_addr;
        instr_d       = instr;
        instr_addr_d  = instr_addr;
        instr_valid_d = instr_valid;
        fetch_err_d   = fetch_err;
        discard_d     = discard;
        cnt_d         = cnt;
        case (state)
            IDLE: begin
                mem_addr_d = i_addr;
                mem_req_d  = 1'b1;
                cnt_d      = '0;
                state_d    = REQ;
            end
            REQ: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    discard_d = 1'b0;
                    state_d   = (discard || flush) ? IDLE : HOLD;
                    if (!discard && !flush) begin
                        instr_d       = mem_data;
                        instr_addr_d  = mem_addr;
                        instr_valid_d = 1'b1;
                    end
                end else if (timeout_hit) begin
                    mem_req_d     = 1'b0;
                    instr_valid_d = 1'b0;
                    fetch_err_d   = 1'b1;
                    state_d       = ERR;
                end else begin
                    discard_d = discard || flush;
                    cnt_d     = &cnt ? cnt : cnt + CW'(1);
                end
            end
            HOLD: begin
                if (flush) begin
                    instr_valid_d = 1'b0;
                    state_d       = IDLE;
                end else if (instr_ready) begin
                    instr_valid_d = 1'b0;
                    mem_addr_d    = i_addr;
                    mem_req_d     = 1'b1;
                    cnt_d         = '0;
                    state_d       = REQ;
                end
            end
            ERR: state_d = ERR;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            instr       <= '0;
            instr_addr  <= '0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
            discard     <= 1'b0;
            cnt         <= '0;
        end else begin
            state       <= state_d;
            mem_req     <= mem_req_d;
            mem_addr    <= mem_addr_d;
            instr       <= instr_d;
            instr_addr  <= instr_addr_d;
            instr_valid <= instr_valid_d;
            fetch_err   <= fetch_err_d;
            discard     <= discard_d;
            cnt         <= cnt_d;
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed vectors against a PC model and a variable-latency memory model
module tb_instruction_fetch;
    logic        clk, rst_n, pc_increment, flush, mem_req, mem_ack, instr_valid, instr_ready, fetch_err;
    logic [15:0] i_addr, mem_addr, mem_data, instr, instr_addr;
    logic [15:0] pc, pc_init, load_val;
    logic        mem_en;
    int          lat, wcnt, inc_cnt, vectors, miscompares, reqc;
    typedef struct {
        logic [15:0] pc;
        int          lat;
        int          hold;
        logic [15:0] instr;
        logic [15:0] next;
    } vec_t;
    vec_t vecs[6];
    instruction_fetch #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .i_addr(i_addr), .pc_increment(pc_increment), .flush(flush),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .instr(instr), .instr_addr(instr_addr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .fetch_err(fetch_err)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    assign i_addr   = pc;
    assign mem_ack  = mem_req && mem_en && (wcnt >= lat);
    assign mem_data = 16'hA000 | mem_addr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= pc_init;
            wcnt    <= 0;
            inc_cnt <= 0;
        end else begin
            pc      <= flush ? load_val : (pc_increment ? pc + 16'd1 : pc);
            wcnt    <= (!mem_req || mem_ack) ? 0 : wcnt + 1;
            inc_cnt <= inc_cnt + (pc_increment ? 1 : 0);
        end
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic start(input logic [15:0] pc0, input int l, input logic en);
        pc_init = pc0;
        lat = l;
        mem_en = en;
        flush = 1'b0;
        instr_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("reset_mem_req", mem_req, 0);
        chk("reset_valid", instr_valid, 0);
        chk("reset_err", fetch_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_req", mem_req, 1);
        chk("first_addr", mem_addr, pc0);
    endtask
    task automatic wait_valid(input logic [15:0] addr, output int n);
        n = 0;
        for (int k = 0; k < 20 && !instr_valid; k++) begin
            if (mem_req) begin
                n++;
                chk("req_addr_stable", mem_addr, addr);
            end
            @(negedge clk);
        end
        chk("valid_seen", instr_valid, 1);
    endtask
    task automatic run_vec(input vec_t v);
        start(v.pc, v.lat, 1'b1);
        wait_valid(v.pc, reqc);
        chk("req_cycles", reqc, v.lat + 1);
        chk("instr", instr, v.instr);
        chk("instr_addr", instr_addr, v.pc);
        chk("inc_once", inc_cnt, 1);
        repeat (v.hold) @(negedge clk);
        chk("hold_instr", instr, v.instr);
        chk("hold_valid", instr_valid, 1);
        chk("hold_no_req", mem_req, 0);
        chk("hold_inc", inc_cnt, 1);
        chk("hold_pc", i_addr, v.next);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        chk("next_req", mem_req, 1);
        chk("next_addr", mem_addr, v.next);
        chk("next_valid_low", instr_valid, 0);
    endtask
    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        instr_ready = 1'b0;
        load_val = 16'h0000;
        pc_init = 16'h0000;
        lat = 0;
        mem_en = 1'b1;
        vecs[0] = '{16'h0000, 0, 0, 16'hA000, 16'h0001};
        vecs[1] = '{16'h0001, 0, 1, 16'hA001, 16'h0002};
        vecs[2] = '{16'h0040, 0, 5, 16'hA040, 16'h0041};
        vecs[3] = '{16'h0FFF, 3, 0, 16'hAFFF, 16'h1000};
        vecs[4] = '{16'hFFFF, 1, 2, 16'hFFFF, 16'h0000};
        vecs[5] = '{16'h1234, 2, 2, 16'hB234, 16'h1235};
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);
        start(16'h0000, 0, 1'b1);
        wait_valid(16'h0000, reqc);
        flush = 1'b1;
        load_val = 16'h0040;
        instr_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        instr_ready = 1'b0;
        chk("hflush_valid", instr_valid, 0);
        chk("hflush_idle", mem_req, 0);
        chk("hflush_pc", i_addr, 16'h0040);
        @(negedge clk);
        chk("hflush_req", mem_req, 1);
        chk("hflush_addr", mem_addr, 16'h0040);
        chk("hflush_inc", inc_cnt, 1);
        start(16'h0010, 2, 1'b1);
        flush = 1'b1;
        load_val = 16'h0040;
        @(negedge clk);
        flush = 1'b0;
        chk("rflush_req", mem_req, 1);
        chk("rflush_addr", mem_addr, 16'h0010);
        chk("rflush_pc", i_addr, 16'h0040);
        @(negedge clk);
        chk("rflush_req2", mem_req, 1);
        chk("rflush_valid", instr_valid, 0);
        @(negedge clk);
        chk("rflush_idle", mem_req, 0);
        chk("rflush_valid2", instr_valid, 0);
        chk("rflush_inc", inc_cnt, 0);
        @(negedge clk);
        chk("rflush_newreq", mem_req, 1);
        chk("rflush_newaddr", mem_addr, 16'h0040);
        wait_valid(16'h0040, reqc);
        chk("rflush_reqc", reqc, 3);
        chk("rflush_instr", instr, 16'hA040);
        chk("rflush_iaddr", instr_addr, 16'h0040);
        chk("rflush_inc2", inc_cnt, 1);
        start(16'h0020, 0, 1'b0);
        reqc = 0;
        for (int k = 0; k < 20 && mem_req; k++) begin
            reqc++;
            @(negedge clk);
        end
        chk("to_cycles", reqc, 8);
        chk("to_err", fetch_err, 1);
        chk("to_req", mem_req, 0);
        chk("to_valid", instr_valid, 0);
        flush = 1'b1;
        instr_ready = 1'b1;
        repeat (3) @(negedge clk);
        flush = 1'b0;
        instr_ready = 1'b0;
        chk("err_sticky", fetch_err, 1);
        chk("err_no_req", mem_req, 0);
        chk("err_no_valid", instr_valid, 0);
        chk("err_inc", inc_cnt, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_err", fetch_err, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
